if_prefetch_queue: RTL

- Parametrised instruction-fetch front end. Successor to the single-register IF stage.
- Decouples PC generation from decode with a DEPTH-entry prefetch FIFO.
- Talks to instruction memory over a request/grant/in-order-response handshake, so multi-cycle or pipelined memories are supported.
- Supports redirect (branch/jump/exception/eret) with queue flush and squash of in-flight responses. Feeds the ID stage through a valid/ready interface.

---
 rtl/if_prefetch_queue.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: request/grant/in-order-response fetch into a DEPTH-entry prefetch FIFO feeding decode.
// Build option IFQ_BYPASS_EN: a response into an empty queue is written straight to the output register.
module if_prefetch_queue #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       DEPTH   = 4,
    parameter logic [ADDR_W-1:0] PC_INIT = ADDR_W'(32'h0040_0000),
    parameter logic [DATA_W-1:0] IR_NON  = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_W-1:0]        imem_rdata,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [DATA_W-1:0]        id_ir,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [ADDR_W-1:0]        id_npc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Fetch-side state
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_discard;
    logic [PTR_W-1:0]  r_rq_wr;
    logic [PTR_W-1:0]  r_rq_rd;
    logic [ADDR_W-1:0] r_rqmem [DEPTH];

    // Instruction FIFO state
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_mem   [DEPTH];
    logic [ADDR_W-1:0] r_pcmem [DEPTH];

    // Registered decode-side outputs
    logic              r_id_valid;
    logic [DATA_W-1:0] r_id_ir;
    logic [ADDR_W-1:0] r_id_pc;
    logic [ADDR_W-1:0] r_id_npc;

    logic [CNT_W:0]    w_credit_used;
    logic              w_req;
    logic              w_accept;
    logic              w_resp_keep;
    logic              w_pop;
    logic [ADDR_W-1:0] w_resp_pc;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_remain;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_head_valid;
    logic [DATA_W-1:0] w_head_ir;
    logic [ADDR_W-1:0] w_head_pc;

    // A slot is reserved for every granted request, so responses always find room.
    assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req         = !reset && !redirect && (w_credit_used < {1'b0, DEPTH_C});
    assign w_accept      = w_req && imem_gnt;
    assign w_resp_keep   = imem_rvalid && (r_discard == '0) && !redirect;
    assign w_pop         = r_id_valid && id_ready && !redirect;
    assign w_resp_pc     = r_rqmem[r_rq_rd];
    assign w_rd_ptr_nxt  = r_rd_ptr + PTR_W'(w_pop);
    assign w_remain      = r_count - CNT_W'(w_pop);
    assign w_count_nxt   = w_remain + CNT_W'(w_resp_keep);

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_ir     = r_id_ir;
    assign id_pc     = r_id_pc;
    assign id_npc    = r_id_npc;
    assign occupancy = r_count;

    // Next head: entries that were already stored before this cycle's push
    always_comb begin
        w_head_valid = 1'b0;
        w_head_ir    = IR_NON;
        w_head_pc    = '0;
        if (w_remain != '0) begin
            w_head_valid = 1'b1;
            w_head_ir    = r_mem[w_rd_ptr_nxt];
            w_head_pc    = r_pcmem[w_rd_ptr_nxt];
        end
`ifdef IFQ_BYPASS_EN
        else if (w_resp_keep) begin
            w_head_valid = 1'b1;
            w_head_ir    = imem_rdata;
            w_head_pc    = w_resp_pc;
        end
`endif
    end

    // Storage arrays need no reset; validity is tracked by the pointers and counters
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rqmem[r_rq_wr] <= r_pc;
        end
        if (w_resp_keep) begin
            r_mem[r_wr_ptr]   <= imem_rdata;
            r_pcmem[r_wr_ptr] <= w_resp_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= PC_INIT;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_rq_wr       <= '0;
            r_rq_rd       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_id_valid    <= 1'b0;
            r_id_ir       <= IR_NON;
            r_id_pc       <= '0;
            r_id_npc      <= ADDR_W'(4);
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(imem_rvalid);
            if (w_accept) begin
                r_rq_wr <= r_rq_wr + PTR_W'(1);
            end
            if (imem_rvalid) begin
                r_rq_rd <= r_rq_rd + PTR_W'(1);
            end
            if (redirect) begin
                // Every response still in flight after this cycle belongs to the old path
                r_pc       <= redirect_pc;
                r_discard  <= r_outstanding - CNT_W'(imem_rvalid) + CNT_W'(w_accept);
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_id_valid <= 1'b0;
                r_id_ir    <= IR_NON;
                r_id_pc    <= '0;
                r_id_npc   <= ADDR_W'(4);
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + ADDR_W'(4);
                end
                if (imem_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - CNT_W'(1);
                end
                if (w_resp_keep) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                r_rd_ptr   <= w_rd_ptr_nxt;
                r_count    <= w_count_nxt;
                r_id_valid <= w_head_valid;
                r_id_ir    <= w_head_ir;
                r_id_pc    <= w_head_pc;
                r_id_npc   <= w_head_pc + ADDR_W'(4);
            end
        end
    end

    // Counter bounds and response ordering sanity
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_count <= DEPTH_C);
            assert (r_outstanding <= DEPTH_C);
            assert (r_discard <= r_outstanding);
            assert (w_credit_used <= {1'b0, DEPTH_C});
            assert (!imem_rvalid || (r_outstanding != '0));
        end
    end

endmodule
